// File: rtl/i2s_rx_fifo_ci_if.sv
// Nios II custom-instruction port bundle for i2s_rx_fifo_ci.
// master = processor side, slave = instruction hardware.
interface i2s_rx_fifo_ci_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (
    output clk_en, start, dataa, datab,
    input  result, done
  );

  modport slave (
    input  clk_en, start, dataa, datab,
    output result, done
  );
endinterface

// File: rtl/i2s_rx_fifo_ci.sv
// I2S left-channel capture into a FIFO popped by a custom instruction.
// Define STEREO_SUM_EN to push (L+R)>>>1 once per stereo pair instead.
module i2s_rx_fifo_ci #(
  parameter  int DEPTH = 64,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             reset,
  i2s_rx_fifo_ci_if.slave ci,
  input logic             i2s_bclk,
  input logic             i2s_lrclk,
  input logic             i2s_sdata
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_SKIP, S_SHIFT, S_WAIT
  } state_t;

  logic [1:0] bclk_sync, lr_sync, sd_sync;
  logic       bclk_q, lr_q;
  logic       rise, lr_s, lr_fall, lr_rise;
  logic       start_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      bclk_q    <= 1'b0;
      lr_q      <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], i2s_bclk};
      lr_sync   <= {lr_sync[0], i2s_lrclk};
      sd_sync   <= {sd_sync[0], i2s_sdata};
      bclk_q    <= bclk_sync[1];
      if (rise) lr_q <= lr_s;
    end
  end

  assign rise    = bclk_sync[1] & ~bclk_q;
  assign lr_s    = lr_sync[1];
  assign lr_fall = rise & lr_q & ~lr_s;
  assign lr_rise = rise & ~lr_q & lr_s;

`ifdef STEREO_SUM_EN
  assign start_ev = lr_fall | lr_rise;
`else
  assign start_ev = lr_fall;
`endif

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [15:0] shreg, shreg_d;
  logic [15:0] word, push_data;
  logic        push;

  assign word = {shreg[14:0], sd_sync[1]};

`ifdef STEREO_SUM_EN
  logic        chan, chan_d;
  logic        have_left, hl_d;
  logic [15:0] left_q, left_d;
  logic [16:0] sum;

  assign sum = {left_q[15], left_q}
             + {word[15], word};
  assign push_data = sum[16:1];
`else
  assign push_data = word;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
`ifdef STEREO_SUM_EN
      chan      <= 1'b0;
      have_left <= 1'b0;
      left_q    <= '0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      shreg <= shreg_d;
`ifdef STEREO_SUM_EN
      chan      <= chan_d;
      have_left <= hl_d;
      left_q    <= left_d;
`endif
    end
  end

  // The delay bit rides on the bclk edge that revealed the
  // lrclk change, so SKIP moves on without waiting for an edge.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    push    = 1'b0;
`ifdef STEREO_SUM_EN
    chan_d  = chan;
    hl_d    = have_left;
    left_d  = left_q;
`endif
    unique case (state)
      S_IDLE, S_WAIT: begin
        if (start_ev) begin
          state_d = S_SKIP;
`ifdef STEREO_SUM_EN
          chan_d = lr_s;
`endif
        end
      end
      S_SKIP: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (rise) begin
          shreg_d = word;
          cnt_d   = cnt + 4'd1;
          if (cnt == 4'd15) begin
            state_d = start_ev ? S_SKIP : S_WAIT;
`ifdef STEREO_SUM_EN
            chan_d = lr_s;
            if (!chan) begin
              left_d = word;
              hl_d   = 1'b1;
            end else begin
              push = have_left;
              hl_d = 1'b0;
            end
`else
            push = 1'b1;
`endif
          end else if (lr_fall | lr_rise) begin
            state_d = start_ev ? S_SKIP : S_IDLE;
`ifdef STEREO_SUM_EN
            chan_d = lr_s;
            hl_d   = 1'b0;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf, full, empty;
  logic             acc, do_pop, do_push;
  logic             do_flush, drop;
  logic             op_pop, op_stat;
  logic             op_flush, op_nop;
  logic [31:0]      res_d, result_q;
  logic             done_q;
  logic             unused_ops;

  assign unused_ops = &{1'b0, ci.dataa, ci.datab[31:2]};

  assign full  = count == CNT_W'(DEPTH);
  assign empty = count == '0;

  assign op_pop   = ci.datab[1:0] == 2'd0;
  assign op_stat  = ci.datab[1:0] == 2'd1;
  assign op_flush = ci.datab[1:0] == 2'd2;
  assign op_nop   = ci.datab[1:0] == 2'd3;

  assign acc      = ci.clk_en & ci.start;
  assign do_pop   = acc & op_pop & ~empty;
  assign do_flush = acc & op_flush;
  assign do_push  = push & ~do_flush
                  & (~full | do_pop);
  assign drop     = push & ~do_flush
                  & full & ~do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (do_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      ovf <= ovf | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    res_d = '0;
    unique case (1'b1)
      op_pop: begin
        if (!empty)
          res_d = {15'b0, 1'b1, mem[rd_ptr]};
      end
      op_stat:
        res_d = {13'b0, full, empty, ovf,
                 16'(count)};
      op_flush, op_nop: res_d = '0;
      default:          res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= acc;
      if (acc) result_q <= res_d;
    end
  end

  assign ci.result = result_q;
  assign ci.done   = done_q;
endmodule

// File: tb/tb_i2s_rx_fifo_ci.sv
// Bench for i2s_rx_fifo_ci: I2S frames against a queue model of the FIFO.
// Build with STEREO_SUM_EN defined to exercise the stereo-sum variant.
module tb_i2s_rx_fifo_ci;
  localparam int DEPTH = 64;
  localparam logic [1:0] OP_POP   = 2'd0;
  localparam logic [1:0] OP_STAT  = 2'd1;
  localparam logic [1:0] OP_FLUSH = 2'd2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic bclk  = 1'b0;
  logic lrclk = 1'b1;
  logic sdata = 1'b0;

  i2s_rx_fifo_ci_if ci();

  i2s_rx_fifo_ci #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .ci(ci),
    .i2s_bclk(bclk),
    .i2s_lrclk(lrclk),
    .i2s_sdata(sdata)
  );

  always #5 clk = ~clk;
  always #40 bclk = ~bclk;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] q[$];
  logic        ovf_m;
  logic [15:0] pend;
  bit          pend_v;
  logic        pend_bit;
  int          gen;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h",
                tag, obs, exp);
  endtask

  function automatic logic [15:0] mval(
    input logic [15:0] l, input logic [15:0] r);
`ifdef STEREO_SUM_EN
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return 16'(s >>> 1);
`else
    return l;
`endif
  endfunction

  function automatic void m_push(input logic [15:0] v);
    if (q.size() < DEPTH) q.push_back(v);
    else ovf_m = 1'b1;
  endfunction

  function automatic logic [31:0] m_pop();
    if (q.size() == 0) return 32'h0;
    return {15'b0, 1'b1, q.pop_front()};
  endfunction

  function automatic logic [31:0] m_stat();
    return {13'b0, q.size() == DEPTH, q.size() == 0,
            ovf_m, 16'(q.size())};
  endfunction

  task automatic bit_out(input logic ws, input logic d);
    @(negedge bclk);
    lrclk = ws;
    sdata = d;
  endtask

  // 32-bclk I2S frame: ws changes one bclk before each MSB
  task automatic frame(input logic [15:0] l,
                       input logic [15:0] r);
    int g = gen;
    bit_out(1'b0, pend_bit);
    for (int i = 15; i >= 1; i--) bit_out(1'b0, l[i]);
    bit_out(1'b1, l[0]);
`ifdef STEREO_SUM_EN
    if (pend_v && g == gen) m_push(pend);
    pend_v = 1'b0;
`endif
    for (int i = 15; i >= 1; i--) bit_out(1'b1, r[i]);
    pend_bit = r[0];
`ifdef STEREO_SUM_EN
    if (g == gen) begin
      pend   = mval(l, r);
      pend_v = 1'b1;
    end
`else
    if (g == gen) m_push(mval(l, r));
`endif
  endtask

  task automatic tail();
    int g = gen;
    bit_out(1'b1, pend_bit);
    repeat (4) bit_out(1'b1, 1'($urandom));
    if (pend_v && g == gen) m_push(pend);
    pend_v = 1'b0;
  endtask

  task automatic partial(input logic [15:0] l,
                         input int nb);
    bit_out(1'b0, pend_bit);
    for (int i = 0; i < nb; i++) bit_out(1'b0, l[15-i]);
    repeat (20) bit_out(1'b1, 1'($urandom));
    pend_bit = 1'($urandom);
    pend_v = 1'b0;
  endtask

  task automatic op_now(input logic [1:0] code,
                        input logic [31:0] exp,
                        input string tag);
    ci.clk_en = 1'b1;
    ci.start  = 1'b1;
    ci.dataa  = $urandom;
    ci.datab  = {30'($urandom), code};
    @(negedge clk);
    ci.start  = 1'b0;
    ci.clk_en = 1'($urandom);
    check({tag, " done"}, 32'(ci.done), 32'd1);
    check(tag, ci.result, exp);
    @(negedge clk);
    check({tag, " done low"}, 32'(ci.done), 32'd0);
  endtask

  task automatic op(input logic [1:0] code,
                    input logic [31:0] exp,
                    input string tag);
    @(negedge clk);
    op_now(code, exp, tag);
  endtask

  task automatic pop_burst(input int n);
    @(negedge clk);
    ci.clk_en = 1'b1;
    ci.start  = 1'b1;
    ci.datab  = {30'($urandom), OP_POP};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) ci.start = 1'b0;
      check("burst done", 32'(ci.done), 32'd1);
      check("burst pop", ci.result, m_pop());
    end
    @(negedge clk);
    check("burst done low", 32'(ci.done), 32'd0);
  endtask

  task automatic pop_on_push(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      seen = dut.push;
    end
    check({tag, " push seen"}, 32'(seen), 32'd1);
    if (seen) op_now(OP_POP, m_pop(), tag);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: no summary by time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp;
    ci.clk_en = 1'b0;
    ci.start  = 1'b0;
    ci.dataa  = '0;
    ci.datab  = '0;
    q.delete();
    ovf_m    = 1'b0;
    pend     = '0;
    pend_v   = 1'b0;
    pend_bit = 1'b0;
    gen      = 0;

    repeat (3) @(negedge clk);
    check("reset result", ci.result, 32'h0);
    check("reset done", 32'(ci.done), 32'd0);
    reset = 1'b0;
    repeat (4) bit_out(1'b1, 1'b0);

    op(OP_POP, 32'h0000_0000, "pop empty");
    op(OP_STAT, 32'h0002_0000, "status empty");

    @(negedge clk);
    ci.clk_en = 1'b0;
    ci.start  = 1'b1;
    ci.datab  = {30'd0, OP_STAT};
    @(negedge clk);
    ci.start  = 1'b0;
    check("gated done", 32'(ci.done), 32'd0);

    frame(16'h1234, 16'($urandom));
    frame(16'hFEDC, 16'($urandom));
    frame(16'h8000, 16'($urandom));
    tail();
    op(OP_POP, m_pop(), "pop 1");
    op(OP_POP, m_pop(), "pop 2");
    op(OP_POP, m_pop(), "pop 3");

`ifdef STEREO_SUM_EN
    frame(16'h7FFF, 16'h7FFF);
    frame(16'h8000, 16'hFFFF);
    tail();
    void'(m_pop());
    op(OP_POP, 32'h0001_7FFF, "stereo max");
    void'(m_pop());
    op(OP_POP, 32'h0001_BFFF, "stereo neg");
`endif

    repeat (5) frame(16'($urandom), 16'($urandom));
    tail();
    op(OP_STAT, m_stat(), "status five");
    pop_burst(6);

    partial(16'hAAAA, 9);
    frame(16'h5555, 16'($urandom));
    tail();
    op(OP_STAT, 32'h0000_0001, "status abort");
    op(OP_POP, m_pop(), "pop abort");

    repeat (65) frame(16'($urandom), 16'($urandom));
    tail();
    op(OP_STAT, 32'h0005_0040, "status overflow");
    q.delete();
    ovf_m = 1'b0;
    op(OP_FLUSH, 32'h0, "flush");
    op(OP_STAT, 32'h0002_0000, "status flushed");

    repeat (63) frame(16'($urandom), 16'($urandom));
    tail();
    fork
      begin
        frame(16'($urandom), 16'($urandom));
        tail();
      end
      pop_on_push("pop at push 63");
    join
    op(OP_STAT, 32'h0000_003F, "status 63");

    frame(16'($urandom), 16'($urandom));
    tail();
    fork
      begin
        frame(16'($urandom), 16'($urandom));
        tail();
      end
      pop_on_push("pop at push full");
    join
    op(OP_STAT, 32'h0004_0040, "status full");
    pop_burst(65);

    frame(16'($urandom), 16'($urandom));
    tail();
    fork
      begin
        frame(16'($urandom), 16'($urandom));
        tail();
      end
      begin
        #700;
        @(negedge clk);
        exp = m_pop();
        ci.clk_en = 1'b1;
        ci.start  = 1'b1;
        ci.datab  = {30'($urandom), OP_POP};
        @(posedge clk);
        #2;
        ci.start = 1'b0;
        check("pre-reset done", 32'(ci.done), 32'd1);
        check("pre-reset pop", ci.result, exp);
        #1;
        reset = 1'b1;
        gen++;
        q.delete();
        ovf_m  = 1'b0;
        pend_v = 1'b0;
        #1;
        check("reset mid result", ci.result, 32'h0);
        check("reset mid done", 32'(ci.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    op(OP_STAT, 32'h0002_0000, "status after reset");
    frame(16'($urandom), 16'($urandom));
    tail();
    op(OP_POP, m_pop(), "pop after reset");
    op(OP_POP, 32'h0, "pop empty end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/i2s_rx_fifo_ci.md
Name: i2s_rx_fifo_ci

Overview:
- Upstream audio capture stage for the moving-average custom instruction.
- Deserializes a 16-bit I2S serial stream (left channel) into signed samples and buffers them in a FIFO.
- Exposes the FIFO to the Nios II as a custom instruction (clk_en/start/done/dataa/datab/result).
- Software pops one sample per instruction and passes result[15:0] to the filter's dataa.

Parameters:
DEPTH, 64, FIFO entries; power of two, 4..1024
CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
clk_en  input  1  custom-instruction clock enable, active high
start  input  1  custom-instruction start; an op is accepted only when start=1 and clk_en=1
dataa  input  32  unused operand; ignored
datab  input  32  op select in datab[1:0]: 0=POP, 1=STATUS, 2=FLUSH, 3=NOP; upper bits ignored
result  output  32  op result, held until the next accepted op
done  output  1  one-cycle pulse marking result valid
i2s_bclk  input  1  serial bit clock, asynchronous; must be slower than clk/4
i2s_lrclk  input  1  word select, asynchronous; 0=left, 1=right
i2s_sdata  input  1  serial data, asynchronous, MSB first

Behaviour:
- Reset (async assert, sync release): result=0, done=0, FIFO pointers=0, count=0, overflow=0, deserializer=IDLE, synchronizers=0.
- Input sync: bclk, lrclk and sdata each pass through a 2-FF synchronizer. A bclk rising edge is detected as sync=1 and previous=0. lrclk is sampled only on detected bclk rising edges.
- Deserializer FSM, advancing only on bclk rising edges:
  - IDLE: on an lrclk 1->0 transition -> SKIP.
  - SKIP: discards the I2S one-bit delay -> SHIFT with bit counter = 0.
  - SHIFT: shift sdata into a 16-bit register, MSB first. After the 16th bit: push the word and go to WAIT.
  - WAIT: ignore further bits. On an lrclk 1->0 transition -> SKIP.
  - An lrclk transition during SHIFT before 16 bits discards the partial word and returns to IDLE (a 1->0 transition goes straight to SKIP).
- Push: one-cycle internal strobe, occurring 3-4 clk after the 16th bclk edge at the pins.
  - FIFO full and no simultaneous pop: sample dropped, sticky overflow set.
- Op handshake: op accepted in cycle N; result updated and done=1 in cycle N+1; done=0 in all other cycles. Back-to-back ops are allowed: start may be asserted every cycle, each giving its own done pulse.
- POP:
  - Non-empty: result = {15'b0, 1'b1, sample[15:0]}; read pointer advances.
  - Empty: result = 32'h0000_0000 (bit16 valid=0).
- STATUS: result = {13'b0, full, empty, overflow, count zero-extended to 16 bits}. Overflow is not cleared.
- FLUSH: pointers, count and overflow cleared; result=0. A push in the same cycle is discarded.
- NOP: result=0, done pulses.
- Simultaneous push and POP:
  - Both take effect and count is unchanged.
  - If the FIFO is full, there is no overflow.
  - If the FIFO is empty, POP returns empty; there is no bypass, and the pushed sample is stored.
- Pointers: width $clog2(DEPTH), natural wrap; count saturates by construction (0..DEPTH).
- Reset mid-op: done and result clear immediately; any in-flight frame is lost.

Optional Feature:
STEREO_SUM_EN
- Defined:
  - The FSM also captures the right channel (lrclk 0->1 transition -> SKIP -> SHIFT).
  - The pushed value is (L+R)>>>1 using a 17-bit signed sum (arithmetic shift, no overflow).
  - One push per L/R pair, occurring after the right word completes.
  - A right word without a preceding complete left word is discarded.
- Not defined: the right channel is ignored entirely and the left sample is pushed as captured.

Test Plan:
- Left words 16'h1234, 16'hFEDC, 16'h8000 sent (I2S, 32 bclk per frame), then 3 POPs -> results 32'h0001_1234, 32'h0001_FEDC, 32'h0001_8000, each with done exactly 1 cycle after the start cycle.
- POP on empty after reset -> result 32'h0000_0000, done pulses once; a following STATUS -> 32'h0002_0000.
- 65 frames with DEPTH=64, then STATUS -> count=64, full=1, overflow=1 (32'h0005_0040). FLUSH, then STATUS -> 32'h0002_0000.
- lrclk toggled after 9 bits of a word 16'hAAAA, then full word 16'h5555 -> exactly one sample (16'h5555) in the FIFO.
- FIFO at 63 entries, POP issued on the push cycle -> count 63, no overflow. Reset asserted mid-frame -> STATUS 32'h0002_0000; the next clean frame is captured correctly.
- With STEREO_SUM_EN: L=16'h7FFF, R=16'h7FFF -> pop 32'h0001_7FFF. L=16'h8000, R=16'hFFFF -> pop 32'h0001_BFFF.
